// File: rtl/sram_arbiter_2p_if.sv
// Purpose: one requester's request channel plus its read-response channel.
// Ports: req_* (valid/ready request carrying write flag, address, data, lane mask),
//        rsp_* (valid/ready read response carrying the captured word).
interface sram_arbiter_2p_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 288,
  parameter int MASK_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  // Requester side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_arbiter_2p.sv
// Purpose: shares one single-port lane-masked SRAM between two requesters, one access per cycle.
// Latency: request ready is combinational; read data is valid 2 cycles after the read is accepted.
// Backpressure: a port's read is held off while it has a read in flight or an unconsumed response.
// Ports: clock/resetn; port0/port1 requester interfaces; sram_* drive the macro, sram_rdata returns from it.
module sram_arbiter_2p #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 288,
  parameter int MASK_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                 clock,
  input  logic                 resetn,
  sram_arbiter_2p_if.slave     port0,
  sram_arbiter_2p_if.slave     port1,
  output logic                 sram_valid,
  output logic                 sram_write,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  output logic [MASK_W-1:0]    sram_wmask,
  input  logic [DATA_W-1:0]    sram_rdata
);

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_INFLIGHT = 2'd1,
    RD_HOLD     = 2'd2
  } rd_state_e;

  localparam bit FIXED = (FIXED_PRIO != 0);

  rd_state_e         state_q [2];
  rd_state_e         state_d [2];
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic              last_grant_q;
  logic              last_grant_d;

  logic [1:0]        req_vld;
  logic [1:0]        req_wr;
  logic [1:0]        rsp_rdy;
  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic              pick0;
  logic [ADDR_W-1:0] req_addr_a  [2];
  logic [DATA_W-1:0] req_wdata_a [2];
  logic [MASK_W-1:0] req_wmask_a [2];

  assign req_vld        = {port1.req_valid, port0.req_valid};
  assign req_wr         = {port1.req_write, port0.req_write};
  assign rsp_rdy        = {port1.rsp_ready, port0.rsp_ready};
  assign req_addr_a[0]  = port0.req_addr;
  assign req_addr_a[1]  = port1.req_addr;
  assign req_wdata_a[0] = port0.req_wdata;
  assign req_wdata_a[1] = port1.req_wdata;
  assign req_wmask_a[0] = port0.req_wmask;
  assign req_wmask_a[1] = port1.req_wmask;

  // Eligibility uses only a port's own state; a held response that is being
  // consumed this cycle frees its slot for a new read in the same cycle.
  always_comb begin
    elig = '0;
    for (int p = 0; p < 2; p++) begin
      elig[p] = req_vld[p] &&
                (req_wr[p] || (state_q[p] == RD_IDLE) ||
                 ((state_q[p] == RD_HOLD) && rsp_rdy[p]));
    end
  end

  // Grants are built from eligibility, never from the other port's ready,
  // so there is no combinational loop between the two ready outputs.
  assign pick0  = FIXED || last_grant_q;
  assign gnt[0] = elig[0] && (!elig[1] || pick0);
  assign gnt[1] = elig[1] && (!elig[0] || !pick0);

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[1])      last_grant_d = 1'b1;
    else if (gnt[0]) last_grant_d = 1'b0;
  end

  assign port0.req_ready = gnt[0];
  assign port1.req_ready = gnt[1];

  always_comb begin
    sram_valid = gnt[0] | gnt[1];
    sram_write = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (gnt[0]) begin
      sram_write = req_wr[0];
      sram_addr  = req_addr_a[0];
      sram_wdata = req_wdata_a[0];
      sram_wmask = req_wr[0] ? req_wmask_a[0] : '0;
    end else if (gnt[1]) begin
      sram_write = req_wr[1];
      sram_addr  = req_addr_a[1];
      sram_wdata = req_wdata_a[1];
      sram_wmask = req_wr[1] ? req_wmask_a[1] : '0;
    end
  end

  // Per-port read tracker. The macro output only survives until the next read
  // by either port, so it is captured the cycle after this port's read.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      rdata_d[p] = rdata_q[p];
      case (state_q[p])
        RD_IDLE: begin
          if (gnt[p] && !req_wr[p]) state_d[p] = RD_INFLIGHT;
        end
        RD_INFLIGHT: begin
          state_d[p] = RD_HOLD;
          rdata_d[p] = sram_rdata;
        end
        RD_HOLD: begin
          if (rsp_rdy[p]) state_d[p] = (gnt[p] && !req_wr[p]) ? RD_INFLIGHT : RD_IDLE;
        end
        default: state_d[p] = RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= RD_IDLE;
        rdata_q[p] <= '0;
      end
      last_grant_q <= 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        rdata_q[p] <= rdata_d[p];
      end
      last_grant_q <= last_grant_d;
    end
  end

  assign port0.rsp_valid = (state_q[0] == RD_HOLD);
  assign port1.rsp_valid = (state_q[1] == RD_HOLD);
  assign port0.rsp_rdata = rdata_q[0];
  assign port1.rsp_rdata = rdata_q[1];

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Purpose: directed and randomized checking of sram_arbiter_2p against a transaction-level model.
// Latency: model predicts grants per cycle and each read response 2 cycles after acceptance.
// Backpressure: rsp_ready is driven low/high directly and randomly to exercise held responses.
module tb_sram_arbiter_2p;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 288;
  localparam int MASK_W = 32;
  localparam int LANE_W = DATA_W / MASK_W;

  logic              clock;
  logic              resetn;
  logic              sram_valid;
  logic              sram_write;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_rdata;

  sram_arbiter_2p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) if0 ();
  sram_arbiter_2p_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) if1 ();

  sram_arbiter_2p #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .FIXED_PRIO(0)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .port0      (if0),
    .port1      (if1),
    .sram_valid (sram_valid),
    .sram_write (sram_write),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wmask (sram_wmask),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- SRAM macro (environment) ----------------
  logic [DATA_W-1:0] macro_mem [256];
  logic [DATA_W-1:0] macro_merged;

  initial begin
    for (int i = 0; i < 256; i++) macro_mem[i] <= '0;
    sram_rdata <= '0;
  end

  always_comb begin
    macro_merged = macro_mem[sram_addr];
    for (int l = 0; l < MASK_W; l++)
      if (sram_wmask[l]) macro_merged[l*LANE_W +: LANE_W] = sram_wdata[l*LANE_W +: LANE_W];
  end

  always @(posedge clock) begin
    if (sram_valid && sram_write)  macro_mem[sram_addr] <= macro_merged;
    if (sram_valid && !sram_write) sram_rdata <= macro_mem[sram_addr];
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory contents as the requesters see them, plus at most one pending
  // read response per port with the cycle at which it becomes visible.
  logic [DATA_W-1:0] exp_mem [256];
  bit                pend_vld [2];
  logic [DATA_W-1:0] pend_dat [2];
  int                pend_vis [2];
  int                last_g;
  int                last_win;
  int                cyc;

  function automatic logic [DATA_W-1:0] apply_mask(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] d,
                                                   input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = old;
    for (int l = 0; l < MASK_W; l++)
      if (m[l]) r[l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rnd288();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int p, input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    if (p == 0) begin
      if0.req_valid = v; if0.req_write = w; if0.req_addr = a; if0.req_wdata = d; if0.req_wmask = m;
    end else begin
      if1.req_valid = v; if1.req_write = w; if1.req_addr = a; if1.req_wdata = d; if1.req_wmask = m;
    end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock cycle: inputs were set after the falling edge; check the DUT
  // against the model, advance the model across the coming rising edge.
  task automatic step();
    bit                v[2], w[2], rr[2], hold[2], elig[2];
    logic [ADDR_W-1:0] a[2];
    logic [DATA_W-1:0] d[2];
    logic [MASK_W-1:0] m[2];
    bit                rdy[2], rv[2];
    logic [DATA_W-1:0] rd[2];
    int                win;
    #2;
    v[0] = if0.req_valid; w[0] = if0.req_write; a[0] = if0.req_addr; d[0] = if0.req_wdata;
    m[0] = if0.req_wmask; rr[0] = if0.rsp_ready;
    v[1] = if1.req_valid; w[1] = if1.req_write; a[1] = if1.req_addr; d[1] = if1.req_wdata;
    m[1] = if1.req_wmask; rr[1] = if1.rsp_ready;
    rdy[0] = if0.req_ready; rv[0] = if0.rsp_valid; rd[0] = if0.rsp_rdata;
    rdy[1] = if1.req_ready; rv[1] = if1.rsp_valid; rd[1] = if1.rsp_rdata;

    for (int p = 0; p < 2; p++) begin
      hold[p] = pend_vld[p] && (pend_vis[p] <= cyc);
      elig[p] = v[p] && (w[p] || !pend_vld[p] || (hold[p] && rr[p]));
    end
    if (elig[0] && elig[1]) win = (last_g == 1) ? 0 : 1;
    else if (elig[0])       win = 0;
    else if (elig[1])       win = 1;
    else                    win = -1;

    check_val("ready0", rdy[0], (win == 0));
    check_val("ready1", rdy[1], (win == 1));
    check_val("sram_valid", sram_valid, (win >= 0));
    if (win >= 0) begin
      check_val("sram_write", sram_write, w[win]);
      check_val("sram_addr", sram_addr, a[win]);
      check_val("sram_wmask", sram_wmask, w[win] ? m[win] : '0);
      if (w[win]) check_val("sram_wdata", sram_wdata, d[win]);
    end else begin
      check_val("sram_idle", {sram_write, sram_addr, sram_wmask, sram_wdata}, '0);
    end
    for (int p = 0; p < 2; p++) begin
      check_val(p == 0 ? "rsp0_valid" : "rsp1_valid", rv[p], hold[p]);
      if (hold[p]) check_val(p == 0 ? "rsp0_rdata" : "rsp1_rdata", rd[p], pend_dat[p]);
    end

    for (int p = 0; p < 2; p++) if (hold[p] && rr[p]) pend_vld[p] = 0;
    if (win >= 0) begin
      last_g = win;
      if (w[win]) begin
        exp_mem[a[win]] = apply_mask(exp_mem[a[win]], d[win], m[win]);
      end else begin
        pend_vld[win] = 1;
        pend_dat[win] = exp_mem[a[win]];
        pend_vis[win] = cyc + 2;
      end
    end
    last_win = win;
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle_all();
    if0.rsp_ready = 1'b0;
    if1.rsp_ready = 1'b0;
    resetn = 1'b0;
    #1;
    check_val("rst_async_rsp_valid", {if1.rsp_valid, if0.rsp_valid}, '0);
    check_val("rst_async_rdata0", if0.rsp_rdata, '0);
    check_val("rst_async_rdata1", if1.rsp_rdata, '0);
    @(posedge clock);
    #1;
    check_val("rst_hold_rsp_valid", {if1.rsp_valid, if0.rsp_valid}, '0);
    @(negedge clock);
    resetn = 1'b1;
    pend_vld[0] = 0;
    pend_vld[1] = 0;
    last_g = 1;
  endtask

  logic [DATA_W-1:0] ones;
  int                k;

  initial begin
    ones   = '1;
    resetn = 1'b0;
    cyc    = 0;
    last_g = 1;
    last_win = -1;
    pend_vld[0] = 0;
    pend_vld[1] = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    idle_all();
    if0.rsp_ready = 1'b0;
    if1.rsp_ready = 1'b0;
    @(negedge clock);
    do_reset();

    // Full write then read back on port 0.
    if0.rsp_ready = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h05, ones, 32'hFFFF_FFFF); step();
    set_req(0, 1'b1, 1'b0, 8'h05, '0, '0);              step();
    idle_all(); step(); step(); step();

    // Partial lane mask: only lane 0 takes the new data.
    if0.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h10, '0, 32'hFFFF_FFFF);   step();
    set_req(0, 1'b1, 1'b1, 8'h10, ones, 32'h0000_0001); step();
    set_req(0, 1'b1, 1'b0, 8'h10, '0, '0);              step();
    idle_all(); step();
    #1;
    check_val("pmask_rdata", if0.rsp_rdata, {{(DATA_W-9){1'b0}}, 9'h1FF});
    if0.rsp_ready = 1'b1;
    step(); step();

    // Both ports writing continuously straight after reset: strict alternation.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1'b1, 1'b1, 8'h40 + 8'(c), rnd288(), 32'hFFFF_FFFF);
      set_req(1, 1'b1, 1'b1, 8'h50 + 8'(c), rnd288(), 32'hFFFF_FFFF);
      step();
      check_val("alt_grant", last_win, c % 2);
    end
    idle_all(); step();

    // Port 1 response held for several cycles while port 0 keeps reading.
    if0.rsp_ready = 1'b1;
    if1.rsp_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 8'h10, '0, '0);
    set_req(0, 1'b1, 1'b0, 8'h20, '0, '0);
    for (int c = 0; c < 7; c++) step();
    if1.rsp_ready = 1'b1;
    step();
    idle_all(); step(); step(); step();

    // Back-to-back reads on port 0 with the consumer always ready.
    if0.rsp_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      set_req(0, 1'b1, 1'b0, 8'(k), '0, '0);
      step();
      if (last_win == 0) k++;
    end
    check_val("b2b_reads_done", k, 4);
    idle_all(); step(); step(); step();

    // Reset while a read is in flight, then a normal read afterwards.
    set_req(0, 1'b1, 1'b0, 8'h05, '0, '0); step();
    do_reset();
    if0.rsp_ready = 1'b1;
    step(); step(); step();
    set_req(0, 1'b1, 1'b0, 8'h10, '0, '0); step();
    idle_all(); step(); step(); step();

    // Reset while a response is being held.
    if0.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h05, '0, '0); step();
    idle_all(); step();
    #1;
    check_val("hold_before_reset", if0.rsp_valid, 1'b1);
    do_reset();
    if0.rsp_ready = 1'b1;
    step(); step();

    // Randomized traffic over a small address window plus occasional far addresses.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        set_req(p, ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
                ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
                rnd288(), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
      end
      if0.rsp_ready = ($urandom_range(0, 9) < 7);
      if1.rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    idle_all();
    if0.rsp_ready = 1'b1;
    if1.rsp_ready = 1'b1;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
